// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words from a synchronous FIFO read port (1-cycle read
// latency) and presents them as a valid/ready stream, split into packets of
// PKT_LEN beats. A 2-entry skid buffer absorbs the in-flight read so that
// pops can be issued speculatively while still sustaining one beat per cycle.
//
// Handshake rules: a beat transfers on a rising edge where m_valid & m_ready.
// m_valid does not depend on m_ready. Once m_valid rises, it stays high, and
// m_data/m_last stay stable, until the beat transfers.
module fifo_rd_stream #(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_rddata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  localparam logic [7:0] LP_LAST_BEAT = 8'(PKT_LEN - 1);

  // Skid buffer: r_buf0 is always the oldest word, r_buf1 the next one.
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [1:0]       r_buf_cnt;
  // High in the cycle where fifo_rddata carries the word popped last cycle.
  logic             r_inflight;
  logic [7:0]       r_beat_cnt;
  // Blocks pops until the first edge after reset release, so no read is
  // issued combinationally in the partial cycle following de-assertion.
  logic             r_run;

  logic             w_pop;
  logic [2:0]       w_occ_next;

  assign m_valid = (r_buf_cnt != 2'd0);
  assign m_data  = r_buf0;
  assign m_last  = m_valid & (r_beat_cnt == LP_LAST_BEAT);
  assign w_pop   = m_valid & m_ready;

  // Occupancy the buffer will have once the in-flight word lands and the
  // current beat (if any) leaves; a new pop is only safe if this is below 2.
  assign w_occ_next = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rden  = r_run & ~fifo_empty & (w_occ_next < 3'd2);

  // Run enable: set on the first clock edge seen with reset released.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // In-flight flag: the FIFO returns data one cycle after each pop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rden;
    end
  end

  // Skid buffer: accept returning read data, shift out on handshake.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_buf_cnt <= 2'd0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          // Write only: land in the first free slot.
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= fifo_rddata;
          end else begin
            r_buf1 <= fifo_rddata;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          // Pop only: advance the head.
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          // Write and pop together: count unchanged, head advances.
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= fifo_rddata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_rddata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Packet beat counter: advances only on a completed handshake.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_beat_cnt <= 8'd0;
    end else if (w_pop) begin
      if (r_beat_cnt == LP_LAST_BEAT) begin
        r_beat_cnt <= 8'd0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream behind a behavioural
// 10-deep, 4-bit synchronous FIFO with 1-cycle read latency, PKT_LEN = 5.
module tb_fifo_rd_stream;

  localparam int W = 4;
  localparam int DEPTH = 10;
  localparam int PKT = 5;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic fifo_rst_n;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // ---------------- DUT + FIFO model ----------------
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata;
  logic         fifo_empty;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_ready;
  logic         fifo_wr;
  logic [W-1:0] fifo_wdata;

  fifo_rd_stream #(.WIDTH(W), .PKT_LEN(PKT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready)
  );

  logic [W-1:0] f_mem [DEPTH];
  int           f_wp;
  int           f_rp;
  int           f_cnt;
  logic [W-1:0] f_rdata;
  logic         f_do_wr;
  logic         f_do_rd;

  assign fifo_empty  = (f_cnt == 0);
  assign fifo_rddata = f_rdata;
  assign f_do_wr     = fifo_wr && (f_cnt < DEPTH);
  assign f_do_rd     = fifo_rden && (f_cnt > 0);

  always @(posedge sys_clk) begin
    if (!fifo_rst_n) begin
      f_wp    <= 0;
      f_rp    <= 0;
      f_cnt   <= 0;
      f_rdata <= '0;
    end else begin
      if (f_do_wr) begin
        f_mem[f_wp] <= fifo_wdata;
        f_wp        <= (f_wp == DEPTH - 1) ? 0 : f_wp + 1;
      end
      if (f_do_rd) begin
        f_rdata <= f_mem[f_rp];
        f_rp    <= (f_rp == DEPTH - 1) ? 0 : f_rp + 1;
      end
      f_cnt <= f_cnt + (f_do_wr ? 1 : 0) - (f_do_rd ? 1 : 0);
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] got_q[$];
  logic         last_q[$];
  int           cyc_q[$];
  int           underflow_cnt = 0;
  int           rst_rden_cnt = 0;
  int           pop_cnt = 0;
  int           first_rden = -1;
  int           first_valid = -1;

  always @(negedge sys_clk) begin
    if (fifo_rden && fifo_empty) underflow_cnt++;
    if (!sys_rst_n && fifo_rden) rst_rden_cnt++;
    if (fifo_rden) begin
      pop_cnt++;
      if (first_rden < 0) first_rden = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (sys_rst_n && m_valid && m_ready) begin
      got_q.push_back(m_data);
      last_q.push_back(m_last);
      cyc_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    cyc_q.delete();
    pop_cnt = 0;
    first_rden = -1;
    first_valid = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill(input int n);
    for (int v = 0; v < n; v++) begin
      fifo_wr    = 1'b1;
      fifo_wdata = W'(v);
      @(posedge sys_clk);
      #1;
    end
    fifo_wr = 1'b0;
  endtask

  task automatic collect(input string tag, input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 200) begin
      @(posedge sys_clk);
      t++;
    end
    @(posedge sys_clk);
    #1;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
  endtask

  // Words 0..n-1 expected in order; m_last on every PKT-th beat.
  task automatic check_stream(input string tag, input int n, input bit consec);
    logic [W-1:0] d;
    logic         l;
    int           c;
    int           prev_c;
    prev_c = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(W'(i));
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front();
      l = last_q.pop_front();
      c = cyc_q.pop_front();
      chk($sformatf("%s_data%0d", tag, i), 32'(d), 32'(exp_q.pop_front()));
      chk($sformatf("%s_last%0d", tag, i), 32'(l), 32'((i % PKT) == PKT - 1));
      if (consec && i > 0) chk($sformatf("%s_gap%0d", tag, i), 32'(c), 32'(prev_c + 1));
      prev_c = c;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_ready    = 1'b0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    sys_rst_n  = 1'b0;
    fifo_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    fifo_rst_n = 1'b1;

    // T1: FIFO filled while the block is held in reset, then full-rate drain.
    fill(10);
    @(negedge sys_clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rden_nonempty", 32'(fifo_rden), 32'd0);
    chk("rst_beat_cnt", 32'(dut.r_beat_cnt), 32'd0);
    chk("rst_buf_cnt", 32'(dut.r_buf_cnt), 32'd0);
    @(posedge sys_clk);
    #1;
    clear_mon();
    m_ready   = 1'b1;
    sys_rst_n = 1'b1;
    #1;
    chk("rel_no_early_rden", 32'(fifo_rden), 32'd0);
    collect("t1", 10);
    check_stream("t1", 10, 1'b1);
    chk("t1_latency", 32'(first_valid - first_rden), 32'd2);
    chk("rst_rden_during_reset", 32'(rst_rden_cnt), 32'd0);
    m_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    // T2: downstream stalled; only 2 pops, head word held stable.
    clear_mon();
    fill(10);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk($sformatf("t2_hold_data%0d", i), 32'(m_data), 32'd0);
      if (i == 7) begin
        chk("t2_hold_valid", 32'(m_valid), 32'd1);
        chk("t2_hold_last", 32'(m_last), 32'd0);
      end
      @(posedge sys_clk);
      #1;
    end
    chk("t2_pops", 32'(pop_cnt), 32'd2);
    m_ready = 1'b1;
    collect("t2", 10);
    check_stream("t2", 10, 1'b1);
    m_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    // T3: m_ready alternating each cycle; beat counter frozen on stalls.
    clear_mon();
    fill(10);
    begin
      int i;
      i = 0;
      while (got_q.size() < 10 && i < 60) begin
        m_ready = ((i % 2) == 0);
        @(negedge sys_clk);
        if (!m_ready) chk($sformatf("t3_beat_frz%0d", i), 32'(dut.r_beat_cnt), 32'(got_q.size() % PKT));
        @(posedge sys_clk);
        #1;
        i++;
      end
    end
    m_ready = 1'b0;
    chk("t3_count", 32'(got_q.size()), 32'd10);
    check_stream("t3", 10, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;

    // T4: FIFO written concurrently, one word per cycle, m_ready high.
    clear_mon();
    m_ready = 1'b1;
    fill(10);
    collect("t4", 10);
    check_stream("t4", 10, 1'b1);
    chk("t4_latency", 32'(first_valid - first_rden), 32'd2);
    m_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    // T5: reset mid-packet with 2 words buffered, then refill 0..4.
    clear_mon();
    fill(10);
    m_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    m_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("t5_pre_count", 32'(got_q.size()), 32'd3);
    check_stream("t5_pre", 3, 1'b1);
    chk("t5_pre_buf_cnt", 32'(dut.r_buf_cnt), 32'd2);
    chk("t5_pre_beat_cnt", 32'(dut.r_beat_cnt), 32'd3);
    sys_rst_n  = 1'b0;
    fifo_rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_beat_cnt", 32'(dut.r_beat_cnt), 32'd0);
    chk("t5_rst_last", 32'(m_last), 32'd0);
    chk("t5_rst_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    clear_mon();
    sys_rst_n  = 1'b1;
    fifo_rst_n = 1'b1;
    m_ready    = 1'b1;
    fill(5);
    collect("t5", 5);
    check_stream("t5", 5, 1'b1);
    m_ready = 1'b0;

    chk("underflow_pops", 32'(underflow_cnt), 32'd0);
    chk("reset_pops", 32'(rst_rden_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
